sync_fifo_pkt: RTL and testbench

Synchronous packet FIFO: a store-and-forward successor to the team's single-word sync FIFO. Words are written with an end-of-packet marker and become readable only when their packet commits; a packet can be discarded mid-write, and one that overflows is dropped automatically. The block sits between packet producers (parsers, DMA engines) and consumers that must never see partial or corrupted frames. The read side is first-word-fall-through with a registered output stage.

---
 rtl/sync_fifo_pkt_if.sv | 29 ++
 rtl/sync_fifo_pkt.sv | 167 ++++++++++++++++
 tb/tb_sync_fifo_pkt.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkt_if.sv
// Packet FIFO bus: write side (producer) and read side (consumer) plus status.
// master drives the FIFO inputs; slave is the FIFO itself.
interface sync_fifo_pkt_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  wr_en;
  logic                  wr_last;
  logic                  wr_drop;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_last;
  logic                  full;
  logic                  afull;
  logic [ADDR_WIDTH+1:0] uw;
  logic [ADDR_WIDTH:0]   pkt_cnt;

  modport master (
    output wr_en, wr_last, wr_drop, data_in, rd_en,
    input  out_valid, data_out, rd_last, full, afull, uw, pkt_cnt
  );

  modport slave (
    input  wr_en, wr_last, wr_drop, data_in, rd_en,
    output out_valid, data_out, rd_last, full, afull, uw, pkt_cnt
  );
endinterface

// File: rtl/sync_fifo_pkt.sv
// Store-and-forward packet FIFO with commit/rewind write pointer and FWFT registered output.
// Define SYNC_FIFO_PKT_ERR_EN to implement the sticky err flags; otherwise err reads 3'b000.
module sync_fifo_pkt #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned AFULL_LEVEL = 248
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sclr,
  input  logic           err_clr,
  output logic [2:0]     err,
  sync_fifo_pkt_if.slave bus
);
  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam int unsigned UwW   = ADDR_WIDTH + 2;

  typedef logic [ADDR_WIDTH:0] ptr_t;
  localparam ptr_t DepthPtr = ptr_t'(Depth);

  logic [DATA_WIDTH:0] mem [Depth];

  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  cm_ptr_q, cm_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  ptr_t                  pkt_cnt_q, pkt_cnt_d;
  ptr_t                  ptr_diff;
  logic                  pkt_bad_q, pkt_bad_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_last_q, rd_last_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic [UwW-1:0]        uw_q, uw_d;
  logic [DATA_WIDTH:0]   rd_word;

  logic wr_fire, wr_ovf, wr_rewind, fetch, pop, commit, pop_last;

  always_comb begin
    wr_fire   = bus.wr_en & ~full_q & ~pkt_bad_q & ~bus.wr_drop;
    wr_ovf    = bus.wr_en & full_q;
    // A packet whose last word cannot be stored ends as a drop right away.
    wr_rewind = bus.wr_drop | (bus.wr_en & bus.wr_last & (pkt_bad_q | full_q));
    commit    = wr_fire & bus.wr_last;
    fetch     = (~out_valid_q | bus.rd_en) & (cm_ptr_q != rd_ptr_q);
    pop       = bus.rd_en & out_valid_q;
    pop_last  = pop & rd_last_q;
  end

  // Write side: speculative pointer, commit pointer and overflow tracking.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cm_ptr_d  = cm_ptr_q;
    pkt_bad_d = pkt_bad_q;
    if (wr_rewind) begin
      wr_ptr_d  = cm_ptr_q;
      pkt_bad_d = 1'b0;
    end else begin
      if (wr_ovf) begin
        pkt_bad_d = 1'b1;
      end
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (commit) begin
        cm_ptr_d = wr_ptr_q + ptr_t'(1);
      end
    end
  end

  // Read side: refill the output register whenever it is empty or being popped.
  always_comb begin
    rd_word     = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    rd_last_d   = rd_last_q;
    if (fetch) begin
      rd_ptr_d    = rd_ptr_q + ptr_t'(1);
      out_valid_d = 1'b1;
      data_out_d  = rd_word[DATA_WIDTH-1:0];
      rd_last_d   = rd_word[DATA_WIDTH];
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  // Status is computed from next-state pointers so the registers track the current state.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (commit && !pop_last) begin
      pkt_cnt_d = pkt_cnt_q + ptr_t'(1);
    end else if (!commit && pop_last) begin
      pkt_cnt_d = pkt_cnt_q - ptr_t'(1);
    end
    ptr_diff = wr_ptr_d - rd_ptr_d;
    full_d   = (ptr_diff == DepthPtr);
    uw_d     = UwW'(ptr_diff) + UwW'(out_valid_d);
    afull_d  = (32'(uw_d) >= AFULL_LEVEL);
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {bus.wr_last, bus.data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || sclr) begin
      wr_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_cnt_q   <= '0;
      pkt_bad_q   <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      rd_last_q   <= 1'b0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      uw_q        <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_cnt_q   <= pkt_cnt_d;
      pkt_bad_q   <= pkt_bad_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      rd_last_q   <= rd_last_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      uw_q        <= uw_d;
    end
  end

`ifdef SYNC_FIFO_PKT_ERR_EN
  logic [2:0] err_q, err_d, err_set;

  // Same-cycle set beats err_clr.
  always_comb begin
    err_set = {wr_rewind, bus.rd_en & ~out_valid_q, wr_ovf};
    err_d   = err_set | (err_clr ? 3'b000 : err_q);
  end

  always_ff @(posedge clk) begin
    if (rst || sclr) begin
      err_q <= 3'b000;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err            = 3'b000;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.full      = full_q;
  assign bus.afull     = afull_q;
  assign bus.uw        = uw_q;
  assign bus.pkt_cnt   = pkt_cnt_q;
endmodule

// File: tb/tb_sync_fifo_pkt.sv
// Bench for sync_fifo_pkt (ADDR_WIDTH=3): vector table plus hand sequences, popped words
// checked against a scoreboard of committed packets.
module tb_sync_fifo_pkt;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 3;
  localparam int unsigned AFL = 6;
  localparam logic [2:0] ErrMask =
`ifdef SYNC_FIFO_PKT_ERR_EN
    3'b111;
`else
    3'b000;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sclr;
  logic       err_clr;
  logic [2:0] err;

  sync_fifo_pkt_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sync_fifo_pkt #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AFULL_LEVEL(AFL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sclr   (sclr),
    .err_clr(err_clr),
    .err    (err),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW:0] sb[$];    // committed words awaiting readout: {last, data}
  logic [DW:0] pend[$];  // words of the packet currently being written
  logic [DW:0] mon_exp;

  typedef struct {
    bit          we;
    bit          wl;
    logic [31:0] d;
    bit          re;
    bit          ov;
    int unsigned pc;
    int unsigned uw;
  } vec_t;

  vec_t vt[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit we, input bit wl, input bit wd, input logic [DW-1:0] d,
                       input bit re);
    bus.wr_en   = we;
    bus.wr_last = wl;
    bus.wr_drop = wd;
    bus.data_in = d;
    bus.rd_en   = re;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic put(input logic [DW-1:0] d, input bit last);
    drive(1'b1, last, 1'b0, d, 1'b0);
    pend.push_back({last, d});
    if (last) begin
      while (pend.size() > 0) sb.push_back(pend.pop_front());
    end
    tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_data_out"}, 64'(bus.data_out), 64'(0));
    check({tag, "_rd_last"}, 64'(bus.rd_last), 64'(0));
    check({tag, "_full"}, 64'(bus.full), 64'(0));
    check({tag, "_afull"}, 64'(bus.afull), 64'(0));
    check({tag, "_uw"}, 64'(bus.uw), 64'(0));
    check({tag, "_pkt_cnt"}, 64'(bus.pkt_cnt), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
  endtask

  // Word popped at the coming rising edge must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && !sclr && bus.rd_en && bus.out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_unexpected: got %0h expected no word", bus.data_out);
      end else begin
        mon_exp = sb.pop_front();
        check("pop_data", 64'(bus.data_out), 64'(mon_exp[DW-1:0]));
        check("pop_last", 64'(bus.rd_last), 64'(mon_exp[DW]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // 3-word packet A1..A3, then streamed 1-word packets S0..S7 under continuous read.
    vt[0] = '{1, 0, 32'hA000_0001, 0, 0, 0, 1};
    vt[1] = '{1, 0, 32'hA000_0002, 0, 0, 0, 2};
    vt[2] = '{1, 1, 32'hA000_0003, 0, 0, 1, 3};
    vt[3] = '{0, 0, 32'h0,         0, 1, 1, 3};
    vt[4] = '{0, 0, 32'h0,         1, 1, 1, 2};
    vt[5] = '{0, 0, 32'h0,         1, 1, 1, 1};
    vt[6] = '{0, 0, 32'h0,         1, 0, 0, 0};
    vt[7] = '{0, 0, 32'h0,         0, 0, 0, 0};
    vt[8] = '{1, 1, 32'h5000_0000, 0, 0, 1, 1};
    vt[9] = '{1, 1, 32'h5000_0001, 0, 1, 2, 2};
    for (int i = 2; i < 8; i++) begin
      vt[8 + i] = '{1, 1, 32'h5000_0000 + 32'(i), 1, 1, 2, 2};
    end
    vt[16] = '{0, 0, 32'h0, 1, 1, 1, 1};
    vt[17] = '{0, 0, 32'h0, 1, 0, 0, 0};

    rst     = 1'b1;
    sclr    = 1'b0;
    err_clr = 1'b0;
    idle(2);
    check_reset_state("reset");
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].we, vt[i].wl, 1'b0, vt[i].d, vt[i].re);
      if (vt[i].we) sb.push_back({vt[i].wl, vt[i].d});
      tick();
      check($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(vt[i].ov));
      check($sformatf("vec%0d_pkt_cnt", i), 64'(bus.pkt_cnt), 64'(vt[i].pc));
      check($sformatf("vec%0d_uw", i), 64'(bus.uw), 64'(vt[i].uw));
    end
    check("vec_err", 64'(err), 64'(0));

    // Drop mid-packet, then a 1-word packet B.
    put(32'hD0D0_0001, 1'b0);
    put(32'hD0D0_0002, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    pend.delete();
    tick();
    check("drop_uw", 64'(bus.uw), 64'(0));
    put(32'hB000_000B, 1'b1);
    check("drop_b_uw", 64'(bus.uw), 64'(1));
    check("drop_err", 64'(err), 64'(3'b100 & ErrMask));
    check("drop_ov_pre", 64'(bus.out_valid), 64'(0));
    idle(1);
    check("drop_ov", 64'(bus.out_valid), 64'(1));
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    idle(1);
    check("drop_ov_post", 64'(bus.out_valid), 64'(0));
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("drop_err_clr", 64'(err), 64'(0));

    // Overflow: 8-word packet fills memory, the following 2-word packet is dropped.
    for (int i = 0; i < 8; i++) put(32'hC0DE_0000 + 32'(i), (i == 7));
    check("ovf_full", 64'(bus.full), 64'(1));
    check("ovf_afull", 64'(bus.afull), 64'(1));
    check("ovf_uw8", 64'(bus.uw), 64'(8));
    drive(1'b1, 1'b0, 1'b0, 32'hE000_0000, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'hE000_0001, 1'b0);
    tick();
    check("ovf_err", 64'(err), 64'(3'b101 & ErrMask));
    check("ovf_pkt_cnt", 64'(bus.pkt_cnt), 64'(1));
    check("ovf_uw", 64'(bus.uw), 64'(8));
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    repeat (8) tick();
    idle(1);
    check("ovf_drain_ov", 64'(bus.out_valid), 64'(0));
    check("ovf_drain_uw", 64'(bus.uw), 64'(0));
    check("ovf_drain_pkt_cnt", 64'(bus.pkt_cnt), 64'(0));

    // Underflow, err_clr, and set-beats-clear.
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("uf_pre_err", 64'(err), 64'(0));
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    tick();
    check("uf_err", 64'(err), 64'(3'b010 & ErrMask));
    check("uf_uw", 64'(bus.uw), 64'(0));
    check("uf_ov", 64'(bus.out_valid), 64'(0));
    err_clr = 1'b1;
    tick();
    check("uf_set_wins", 64'(err), 64'(3'b010 & ErrMask));
    idle(1);
    err_clr = 1'b0;
    check("uf_err_clr", 64'(err), 64'(0));

    // Synchronous clear with a partial packet in flight.
    put(32'h5C15_0000, 1'b0);
    sclr = 1'b1;
    idle(1);
    sclr = 1'b0;
    pend.delete();
    check("sclr_uw", 64'(bus.uw), 64'(0));

    // Reset mid-packet with one committed packet stored, then packet C.
    put(32'hF000_0000, 1'b1);
    put(32'hF000_0001, 1'b0);
    put(32'hF000_0002, 1'b0);
    rst = 1'b1;
    idle(1);
    check_reset_state("rst_mid");
    rst = 1'b0;
    sb.delete();
    pend.delete();
    put(32'hCC00_0000, 1'b0);
    put(32'hCC00_0001, 1'b1);
    idle(1);
    check("c_ov", 64'(bus.out_valid), 64'(1));
    check("c_pkt_cnt", 64'(bus.pkt_cnt), 64'(1));
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    repeat (2) tick();
    idle(1);
    check("c_ov_post", 64'(bus.out_valid), 64'(0));
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
